ula_acc: RTL and testbench

Sequential accumulator front end for the 2-bit ALU datapath. It accepts one command at a time through a start/ready handshake and applies it to an internal accumulator (ACC) with operand B. It performs add, subtract, AND and OR in one execute cycle, and multiply as a multi-cycle shift-free repeated-add loop. It sits between the control/sequencing logic (the command issuer) and the result consumers.

---
 rtl/ula_acc.sv | 161 ++++++++++++++++
 tb/tb_ula_acc.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ula_acc.sv
// Sequential accumulator front end: one command at a time through start/ready,
// single-cycle ADD/SUB/AND/OR/LOAD/CLR/NOP and repeated-add MUL into ACC/HI.
module ula_acc #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] B,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] ACC,
    output logic [W-1:0] HI,
    output logic         Cout,
    output logic         Z
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_LOAD = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [2:0]     r_op;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_cnt;
    logic [2*W-1:0] r_p;
    logic [2*W-1:0] r_m;
    logic [W-1:0]   r_acc;
    logic [W-1:0]   r_hi;
    logic           r_cout;
    logic           r_z;
    logic           r_done;

    logic [W:0]     w_sum;
    logic [W:0]     w_diff;
    logic [W-1:0]   w_exec_acc;
    logic           w_exec_cout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (op == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: w_next = S_IDLE;
            S_MUL: begin
                if (r_cnt == '0) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // SUB is ACC + ~B + 1, so the carry out reads as "no borrow".
    assign w_sum  = {1'b0, r_acc} + {1'b0, r_b};
    assign w_diff = {1'b0, r_acc} + {1'b0, ~r_b} + {{W{1'b0}}, 1'b1};

    always_comb begin
        w_exec_acc  = r_acc;
        w_exec_cout = 1'b0;
        case (r_op)
            OP_ADD:  {w_exec_cout, w_exec_acc} = w_sum;
            OP_SUB:  {w_exec_cout, w_exec_acc} = w_diff;
            OP_AND:  w_exec_acc = r_acc & r_b;
            OP_OR:   w_exec_acc = r_acc | r_b;
            OP_LOAD: w_exec_acc = r_b;
            OP_CLR:  w_exec_acc = '0;
            default: begin
                w_exec_acc  = r_acc;
                w_exec_cout = r_cout;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= OP_NOP;
            r_b    <= '0;
            r_cnt  <= '0;
            r_p    <= '0;
            r_m    <= '0;
            r_acc  <= '0;
            r_hi   <= '0;
            r_cout <= 1'b0;
            r_z    <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op <= op;
                        r_b  <= B;
                        if (op == OP_MUL) begin
                            r_cnt <= B;
                            r_p   <= '0;
                            r_m   <= {{W{1'b0}}, r_acc};
                        end
                    end
                end
                S_EXEC: begin
                    r_done <= 1'b1;
                    if (r_op != OP_NOP) begin
                        r_acc  <= w_exec_acc;
                        r_cout <= w_exec_cout;
                        r_z    <= (w_exec_acc == '0);
                        if (r_op == OP_CLR) begin
                            r_hi <= '0;
                        end
                    end
                end
                S_MUL: begin
                    // Product of two W-bit values fits in 2W bits, so P cannot wrap.
                    if (r_cnt != '0) begin
                        r_p   <= r_p + r_m;
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_acc  <= r_p[W-1:0];
                        r_hi   <= r_p[2*W-1:W];
                        r_cout <= |r_p[2*W-1:W];
                        r_z    <= (r_p[W-1:0] == '0);
                        r_done <= 1'b1;
                    end
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign ready = (r_state == S_IDLE);
    assign done  = r_done;
    assign ACC   = r_acc;
    assign HI    = r_hi;
    assign Cout  = r_cout;
    assign Z     = r_z;

endmodule

// File: tb/tb_ula_acc.sv
// Directed bench for ula_acc: table of commands with hand-computed results and
// latencies, plus reset and mid-command reset sequences.
module tb_ula_acc;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_LOAD = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;
    localparam int NV = 23;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = 3'b0;
    logic [1:0] B = 2'b0;
    logic       ready, done, Cout, Z;
    logic [1:0] ACC, HI;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] op;
        logic [1:0] b;
        bit         poke;
        int         lat;
        logic [1:0] acc;
        logic [1:0] hi;
        logic       cout;
        logic       z;
    } vec_t;

    vec_t tv [NV];

    ula_acc #(.W(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .B    (B),
        .ready(ready),
        .done (done),
        .ACC  (ACC),
        .HI   (HI),
        .Cout (Cout),
        .Z    (Z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1:0] acc, input logic [1:0] hi,
                             input logic cout, input logic z);
        chk({tag, ".ACC"}, int'(ACC), int'(acc));
        chk({tag, ".HI"}, int'(HI), int'(hi));
        chk({tag, ".Cout"}, int'(Cout), int'(cout));
        chk({tag, ".Z"}, int'(Z), int'(z));
    endtask

    // Issue one command; return edges from acceptance until done is seen.
    task automatic run_cmd(input logic [2:0] o, input logic [1:0] b, input bit poke,
                           output int lat);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        B     = b;
        @(posedge clk);
        #1;
        chk("ready_low_after_accept", int'(ready), 0);
        chk("done_low_after_accept", int'(done), 0);
        B = 2'($urandom);
        if (poke) begin
            op = OP_CLR;
        end else begin
            start = 1'b0;
            op    = 3'($urandom);
        end
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk("ready_with_done", int'(ready), 1);
    endtask

    initial begin
        int lat;
        bit saw_done;

        tv[0]  = '{OP_LOAD, 2'd3, 1'b0, 1, 2'd3, 2'd0, 1'b0, 1'b0};
        tv[1]  = '{OP_ADD,  2'd2, 1'b0, 1, 2'd1, 2'd0, 1'b1, 1'b0};
        tv[2]  = '{OP_LOAD, 2'd1, 1'b0, 1, 2'd1, 2'd0, 1'b0, 1'b0};
        tv[3]  = '{OP_SUB,  2'd2, 1'b0, 1, 2'd3, 2'd0, 1'b0, 1'b0};
        tv[4]  = '{OP_LOAD, 2'd1, 1'b0, 1, 2'd1, 2'd0, 1'b0, 1'b0};
        tv[5]  = '{OP_SUB,  2'd1, 1'b0, 1, 2'd0, 2'd0, 1'b1, 1'b1};
        tv[6]  = '{OP_LOAD, 2'd3, 1'b0, 1, 2'd3, 2'd0, 1'b0, 1'b0};
        tv[7]  = '{OP_MUL,  2'd3, 1'b1, 4, 2'd1, 2'd2, 1'b1, 1'b0};
        tv[8]  = '{OP_LOAD, 2'd2, 1'b0, 1, 2'd2, 2'd2, 1'b0, 1'b0};
        tv[9]  = '{OP_AND,  2'd3, 1'b0, 1, 2'd2, 2'd2, 1'b0, 1'b0};
        tv[10] = '{OP_OR,   2'd1, 1'b0, 1, 2'd3, 2'd2, 1'b0, 1'b0};
        tv[11] = '{OP_MUL,  2'd0, 1'b0, 1, 2'd0, 2'd0, 1'b0, 1'b1};
        tv[12] = '{OP_LOAD, 2'd3, 1'b0, 1, 2'd3, 2'd0, 1'b0, 1'b0};
        tv[13] = '{OP_ADD,  2'd1, 1'b0, 1, 2'd0, 2'd0, 1'b1, 1'b1};
        tv[14] = '{OP_LOAD, 2'd2, 1'b0, 1, 2'd2, 2'd0, 1'b0, 1'b0};
        tv[15] = '{OP_MUL,  2'd2, 1'b0, 3, 2'd0, 2'd1, 1'b1, 1'b1};
        tv[16] = '{OP_NOP,  2'd3, 1'b0, 1, 2'd0, 2'd1, 1'b1, 1'b1};
        tv[17] = '{OP_SUB,  2'd1, 1'b0, 1, 2'd3, 2'd1, 1'b0, 1'b0};
        tv[18] = '{OP_CLR,  2'd2, 1'b0, 1, 2'd0, 2'd0, 1'b0, 1'b1};
        tv[19] = '{OP_LOAD, 2'd3, 1'b0, 1, 2'd3, 2'd0, 1'b0, 1'b0};
        tv[20] = '{OP_SUB,  2'd3, 1'b0, 1, 2'd0, 2'd0, 1'b1, 1'b1};
        tv[21] = '{OP_LOAD, 2'd3, 1'b0, 1, 2'd3, 2'd0, 1'b0, 1'b0};
        tv[22] = '{OP_MUL,  2'd2, 1'b1, 3, 2'd2, 2'd1, 1'b1, 1'b0};

        // Reset held with start asserted and random operands.
        start = 1'b1;
        op    = OP_LOAD;
        B     = 2'd3;
        repeat (3) begin
            @(posedge clk);
            op = 3'($urandom);
            B  = 2'($urandom);
            #1;
        end
        chk("rst.ready", int'(ready), 1);
        chk("rst.done", int'(done), 0);
        chk_state("rst", 2'd0, 2'd0, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst.ready", int'(ready), 1);
        chk("post_rst.done", int'(done), 0);
        chk("post_rst.ACC", int'(ACC), 0);

        for (int i = 0; i < NV; i++) begin
            run_cmd(tv[i].op, tv[i].b, tv[i].poke, lat);
            chk($sformatf("v%0d.latency", i), lat, tv[i].lat);
            chk_state($sformatf("v%0d", i), tv[i].acc, tv[i].hi, tv[i].cout, tv[i].z);
        end
        @(posedge clk);
        #1;
        chk("done_single_cycle", int'(done), 0);

        // Reset one cycle after a MUL is accepted aborts it.
        run_cmd(OP_LOAD, 2'd2, 1'b0, lat);
        chk_state("pre_abort", 2'd2, 2'd1, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        op    = OP_MUL;
        B     = 2'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("abort.busy", int'(ready), 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort.ready", int'(ready), 1);
        chk("abort.done", int'(done), 0);
        chk_state("abort", 2'd0, 2'd0, 1'b0, 1'b1);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("abort.no_done", int'(saw_done), 0);
        chk_state("abort_held", 2'd0, 2'd0, 1'b0, 1'b1);
        run_cmd(OP_ADD, 2'd1, 1'b0, lat);
        chk("after_abort.latency", lat, 1);
        chk_state("after_abort", 2'd1, 2'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
